xor_lane_arbiter: RTL
=====================

XOR_LANE_ARBITER -- requirements
Module: xor_lane_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters sharing the XOR lane (2..8).
REQ-002 Parameter W, default 12, operand width (one packed [2:0][2:1][4:4][1:0] word).
REQ-003 The clocking SHALL be one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N_REQ  per-requester request level.
REQ-007 req_data  input  N_REQ x W  per-requester operand, packed, requester i at slice i.
REQ-008 cfg_key  input  W  XOR key, sampled in the grant cycle only.
REQ-009 gnt  output  N_REQ  one-hot grant pulse, one cycle.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 res_data  output  W  operand XOR key.
REQ-013 res_par  output  1  XOR-reduction (parity) of the captured operand.
REQ-014 res_id  output  ceil(log2 N_REQ)  index of the granted requester.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done_cnt  output  8  count of completed transfers, wraps 255->0.

Function
REQ-017 FSM states SHALL be IDLE, EXEC and RESP, encoded as a single state register.
REQ-018 IDLE: if req is nonzero, the block SHALL assert gnt to the first set bit at or after ptr (modulo N_REQ), capture req_data slice, cfg_key and index, and move to EXEC; otherwise stay in IDLE.
REQ-019 gnt SHALL be combinational from state, req and ptr; it is asserted only in IDLE and for exactly one cycle per transaction.
REQ-020 ptr SHALL update in the grant cycle to (granted index + 1) mod N_REQ; ptr is unchanged in all other cycles.
REQ-021 EXEC: the block SHALL register res_data = op ^ key, res_par = ^op, res_id = captured index, then move to RESP; EXEC lasts exactly one cycle.
REQ-022 RESP: res_valid SHALL be 1, and res_data, res_par and res_id SHALL be held stable until res_valid and res_ready are both high in the same cycle.
REQ-023 On handshake the block SHALL return to IDLE, deassert res_valid next cycle, and increment done_cnt by 1 modulo 256.
REQ-024 Latency: grant at cycle T gives res_valid at T+2; minimum issue interval is 3 cycles, reached when res_ready is held high.
REQ-025 Requests arriving while busy SHALL be ignored until IDLE; they are neither queued nor lost if still asserted.
REQ-026 A requester deasserting req before its grant SHALL not be granted; requests are level-sensitive, not latched.
REQ-027 req_data and cfg_key changes after the grant cycle SHALL NOT affect the in-flight result.
REQ-028 res_ready asserted while res_valid is low SHALL have no effect.

Reset
REQ-029 With rst_n low, asynchronously: state = IDLE, ptr = 0, res_valid = 0, res_data = 0, res_par = 0, res_id = 0, done_cnt = 0, busy = 0.
REQ-030 gnt SHALL be 0 while rst_n is low, regardless of req.
REQ-031 Reset asserted in EXEC or RESP SHALL abort the transaction without incrementing done_cnt; the first post-release grant SHALL start from ptr = 0.
REQ-032 Release of rst_n SHALL take effect on the first rising clk edge after deassertion; no grant occurs in the release cycle before that edge.

Verification
REQ-033 Single request: req=3'b010, req_data[1]=12'hA5C, cfg_key=12'h0FF, res_ready=1 -> gnt=3'b010 at T, res_valid at T+2, res_data=12'hAA3, res_par=0, res_id=1, done_cnt=1.
REQ-034 Round robin: req=3'b111 held, res_ready=1 -> grant order 0,1,2,0 at T, T+3, T+6, T+9; done_cnt=4 after the fourth handshake.
REQ-035 Backpressure: res_ready=0 for 5 cycles in RESP -> res_valid, res_data and res_id remain constant; no gnt; one handshake on release, then IDLE.
REQ-036 Reset mid-transaction: rst_n low during EXEC -> res_valid=0, done_cnt unchanged, ptr=0; after release req=3'b110 -> gnt=3'b010.
REQ-037 Wrap: 256 completed transfers -> done_cnt reads 0; operand 12'hFFF with key 12'hFFF -> res_data=0, res_par=0.
REQ-038 Late data change: req_data[0] changed in cycle T+1 after grant at T -> result reflects the value at T.

Source files
------------

// File: rtl/xor_lane_arbiter.sv
// Round-robin arbiter that lends one shared XOR lane to N_REQ requesters:
// grant, capture operand and key, compute op^key and parity, hold for handshake.
module xor_lane_arbiter #(
  parameter int N_REQ = 3,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       req_data,
  input  logic [W-1:0]             cfg_key,
  output logic [N_REQ-1:0]         gnt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic                     res_par,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic                     busy,
  output logic [7:0]               done_cnt
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           run_q;
  logic [W-1:0]   op_q, key_q;
  logic [IDW-1:0] idx_q;
  logic           res_valid_q;
  logic [W-1:0]   res_data_q;
  logic           res_par_q;
  logic [IDW-1:0] res_id_q;
  logic [7:0]     done_cnt_q;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic           grant;

  function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDW-1:0];
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop or case can leave a latch behind.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_vld && req[wrap_idx(int'(ptr_q), k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(int'(ptr_q), k);
      end
    end
  end

  // run_q holds off grants until the first edge after reset release.
  assign grant = run_q && (state_q == S_IDLE) && pick_vld;
  assign gnt   = grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << pick_idx) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_EXEC;
          ptr_d   = wrap_idx(int'(pick_idx), 1);
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an asynchronous active-low
  // reset; every register, datapath included, clears so outputs read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      run_q       <= 1'b0;
      op_q        <= '0;
      key_q       <= '0;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_par_q   <= 1'b0;
      res_id_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      run_q   <= 1'b1;
      if (grant) begin
        op_q  <= req_data[pick_idx*W +: W];
        key_q <= cfg_key;
        idx_q <= pick_idx;
      end
      if (state_q == S_EXEC) begin
        res_data_q  <= op_q ^ key_q;
        res_par_q   <= ^op_q;
        res_id_q    <= idx_q;
        res_valid_q <= 1'b1;
      end else if (state_q == S_RESP && res_ready) begin
        res_valid_q <= 1'b0;
        done_cnt_q  <= done_cnt_q + 8'd1;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_par   = res_par_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != S_IDLE);
  assign done_cnt  = done_cnt_q;

endmodule
